// File: rtl/jtag_types_pkg.sv
// Shared types for the asynchronous FIFO read-side logic.
//
// Contents:
//   afifo_rd_state_t  - unload controller state encoding
//   lane_count_width  - bits needed to hold a lane count of 0..bytes_per_word
package jtag_types_pkg;

    typedef enum logic [1:0] {
        RC_IDLE    = 2'd0,
        RC_FILL    = 2'd1,
        RC_PRESENT = 2'd2
    } afifo_rd_state_t;

    function automatic int lane_count_width(input int bytes_per_word);
        return $clog2(bytes_per_word + 1);
    endfunction

endpackage

// File: rtl/afifo_rd_timer.sv
// Saturating idle counter for the read-side unload controller.
//
// Ports:
//   rclk     in   read-domain clock
//   r_nrst   in   synchronous active-low reset
//   clear    in   force the count back to zero (highest priority after reset)
//   tick     in   count one idle cycle
//   expired  out  count has reached TIMEOUT (never asserted when TIMEOUT=0)
module afifo_rd_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic rclk,
    input  logic r_nrst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] count_q;

    // Counter holds at TMAX so a long-idle partial word keeps requesting presentation.
    // With TIMEOUT=0 TMAX is zero, so the counter never moves and expired stays low.
    always_ff @(posedge rclk) begin
        if (!r_nrst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick && (count_q != TMAX)) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count_q == TMAX);

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side unload controller for the asynchronous FIFO (rclk domain only).
// Pops first-word-fall-through entries and packs them into words, lane 0 first.
// A word is presented when full, on flush, or after an idle timeout.
//
// Ports:
//   rclk       in   read-domain clock
//   r_nrst     in   synchronous active-low reset
//   enable     in   allow popping from the FIFO
//   flush      in   request presentation of a partial word
//   empty      in   FIFO empty flag
//   rdata      in   FIFO head entry, valid while empty=0
//   rinc       out  pop strobe to the FIFO
//   out_valid  out  packed word valid (registered)
//   out_ready  in   consumer accepts the word
//   out_data   out  packed word, unused lanes zero
//   out_count  out  number of valid lanes in out_data
module afifo_rd_ctrl
    import jtag_types_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                                   rclk,
    input  logic                                   r_nrst,
    input  logic                                   enable,
    input  logic                                   flush,
    input  logic                                   empty,
    input  logic [DATA_WIDTH-1:0]                  rdata,
    output logic                                   rinc,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0]   out_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]    out_count
);

    localparam int CW = lane_count_width(BYTES_PER_WORD);
    localparam int WW = DATA_WIDTH * BYTES_PER_WORD;
    localparam logic [CW-1:0] LAST_LANE = CW'(BYTES_PER_WORD - 1);

    afifo_rd_state_t state_q;
    afifo_rd_state_t state_d;

    logic [CW-1:0] count_q;
    logic [WW-1:0] pack_q;
    logic          out_valid_q;
    logic          pop;
    logic          handshake;
    logic          timer_clear;
    logic          timer_tick;
    logic          timer_expired;

    // Gating with r_nrst keeps the FIFO untouched during the reset cycle even though
    // the state register only returns to IDLE at the reset edge.
    assign pop       = r_nrst && (state_q == RC_FILL) && enable && !empty;
    assign rinc      = pop;
    assign handshake = out_valid_q && out_ready;

    // Next-state logic. A pop on the last lane or together with a flush presents at the
    // same edge, so the popped entry is always part of the presented word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RC_IDLE: begin
                if (enable) begin
                    state_d = RC_FILL;
                end
            end
            RC_FILL: begin
                if (pop) begin
                    if ((count_q == LAST_LANE) || flush) begin
                        state_d = RC_PRESENT;
                    end
                end else if (count_q != '0) begin
                    if (flush || timer_expired) begin
                        state_d = RC_PRESENT;
                    end
                end else if (!enable) begin
                    state_d = RC_IDLE;
                end
            end
            RC_PRESENT: begin
                if (handshake) begin
                    state_d = enable ? RC_FILL : RC_IDLE;
                end
            end
            default: begin
                state_d = RC_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!r_nrst) begin
            state_q <= RC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The timer only runs while a partial word sits in FILL without new entries arriving.
    assign timer_clear = pop || (state_q != RC_FILL) || (state_d == RC_PRESENT);
    assign timer_tick  = (state_q == RC_FILL) && (count_q != '0) && !pop;

    afifo_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .rclk    (rclk),
        .r_nrst  (r_nrst),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // Packing register doubles as out_data. Lanes are zeroed after each handshake so a
    // later partial word shows zeros in its unused lanes.
    always_ff @(posedge rclk) begin
        if (!r_nrst) begin
            count_q     <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (handshake) begin
            count_q     <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                pack_q[count_q*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                count_q <= count_q + CW'(1);
            end
            if ((state_q == RC_FILL) && (state_d == RC_PRESENT)) begin
                out_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = pack_q;
    assign out_count = count_q;

endmodule
